// File: rtl/ghffe_input_pkg.sv
// rtl/ghffe_input_pkg.sv - shared clock/debounce constants for the input conditioner
package ghffe_input_pkg;

    localparam int unsigned CLK_HZ            = 100_000_000;
    localparam int unsigned DEBOUNCE_MS       = 10;
    localparam int unsigned DB_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // The counter must be able to hold DB_CYCLES itself without wrapping
    function automatic int unsigned cnt_width(input int unsigned db_cycles);
        int unsigned w;
        w = $clog2(db_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one channel: synchroniser, stability counter, clean level, edge pulses
module debounce_ch
    import ghffe_input_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic noisy_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], noisy_i};
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // DB_CYCLES consecutive differing cycles: accept the new level
            clean_d = sync;
            cnt_d   = '0;
            rise_d  = sync;
            fall_d  = ~sync;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_o = clean_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - N_CH debounced inputs with edge pulses and optional toggle latches
module input_conditioner
    import ghffe_input_pkg::*;
#(
    parameter int unsigned     N_CH        = 8,
    parameter int unsigned     DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter logic [N_CH-1:0] TOGGLE_MASK = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] noisy,
    input  logic [N_CH-1:0] clear_toggle,
    output logic [N_CH-1:0] clean,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] state,
    output logic            any_change
);

    logic [N_CH-1:0] toggle_q, toggle_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DB_CYCLES  (DB_CYCLES),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_debounce_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .noisy_i(noisy[i]),
            .clean_o(clean[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    // Clear takes priority over a coincident rise; non-toggle bits stay parked at 0
    always_comb begin
        toggle_d = toggle_q;
        for (int i = 0; i < N_CH; i++) begin
            if (!TOGGLE_MASK[i]) begin
                toggle_d[i] = 1'b0;
            end else if (clear_toggle[i]) begin
                toggle_d[i] = 1'b0;
            end else if (rise[i]) begin
                toggle_d[i] = ~toggle_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q <= '0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign state      = (TOGGLE_MASK & toggle_q) | (~TOGGLE_MASK & clean);
    assign any_change = |(rise | fall);

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter N_CH, default 8: number of independent input channels (1..32).
REQ-002 Parameter DB_CYCLES, default 1_000_000: stable-cycle count required to accept a level change (10 ms at 100 MHz); legal range 1..2^24-1.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser depth, minimum 2.
REQ-004 Parameter TOGGLE_MASK, default all zeros (N_CH bits): a set bit puts that channel in toggle mode.
REQ-005 Port clk, input, 1: single system clock (100 MHz); all logic lives in this one domain.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port noisy, input, N_CH: raw asynchronous switch/button levels.
REQ-008 Port clear_toggle, input, N_CH: synchronous per-channel clear of the toggle state.
REQ-009 Port clean, output, N_CH: debounced level.
REQ-010 Port rise, output, N_CH: one-cycle pulse on each accepted 0->1 change of clean.
REQ-011 Port fall, output, N_CH: one-cycle pulse on each accepted 1->0 change of clean.
REQ-012 Port state, output, N_CH: toggle-mode channels give the latched toggle bit; other channels mirror clean.
REQ-013 Port any_change, output, 1: OR of rise and fall, asserted in the same cycle as them.

Function
REQ-014 Each noisy bit SHALL pass through a SYNC_STAGES-deep flip-flop chain; the last stage is called sync.
REQ-015 Each channel SHALL keep a counter of width clog2(DB_CYCLES+1); the counter clears whenever sync equals clean.
REQ-016 While sync differs from clean, the counter SHALL increment once per cycle.
REQ-017 When the counter would reach DB_CYCLES, clean SHALL take the value of sync on that edge and the counter SHALL clear.
REQ-018 Latency: a clean, stable edge on noisy SHALL appear on clean exactly SYNC_STAGES+DB_CYCLES cycles later.
REQ-019 A glitch (sync differs for fewer than DB_CYCLES consecutive cycles) SHALL leave clean and all pulses unchanged, and SHALL reset the counter.
REQ-020 The counter SHALL never wrap; with DB_CYCLES=1, clean follows sync with a one-cycle delay.
REQ-021 rise and fall SHALL be registered and high for exactly one cycle, on the same edge that clean changes; they are never both high on one channel.
REQ-022 Toggle-mode channels SHALL flip state on each rise; fall has no effect on state.
REQ-023 clear_toggle SHALL force state to 0 at the next edge; if clear_toggle and rise coincide, clear wins and state is 0.
REQ-024 clear_toggle on a non-toggle channel SHALL have no effect.
REQ-025 Channels SHALL operate fully independently, with no shared counters.

Reset
REQ-026 While reset_n is low: synchroniser flops, counters, clean, rise, fall, state and any_change SHALL all be 0.
REQ-027 Reset asserted mid-count SHALL discard the partial count; after release, an input that is already high SHALL need the full SYNC_STAGES+DB_CYCLES cycles and then produce one rise.
REQ-028 Reset release SHALL be synchronised in the parent; this block makes no release-timing guarantee beyond that.

Structure
REQ-029 The shared package ghffe_input_pkg SHALL hold the default constants CLK_HZ=100_000_000, DEBOUNCE_MS=10 and the derived DB_CYCLES default.
REQ-030 One sub-module, debounce_ch (synchroniser, counter, clean, edge pulses), SHALL be instantiated N_CH times by a generate loop; toggle and any_change logic stay in the top module.
REQ-031 No other sub-modules; the top-level game module SHALL replace its per-button debounce instances with one input_conditioner.

Verification (bench: N_CH=4, DB_CYCLES=4, SYNC_STAGES=2, TOGGLE_MASK=4'b0010)
REQ-032 noisy[0] 0->1 held -> clean[0]=1 and rise[0] one-cycle pulse 6 cycles after the edge; any_change high in that cycle.
REQ-033 noisy[0] pulsed high for 3 cycles -> clean, rise and fall stay 0 throughout.
REQ-034 noisy[1] pressed and released twice with 10-cycle holds -> state[1] goes 1 then 0; clean[1] shows two rise and two fall pulses.
REQ-035 clear_toggle[1] in the same cycle as rise[1] -> state[1]=0; clear_toggle[0] -> no change on channel 0.
REQ-036 reset_n low at counter=3 with noisy[2]=1 -> all outputs 0; after release, rise[2] appears exactly 6 cycles later.
REQ-037 noisy=4'b1111 simultaneously -> all four rise bits pulse in the same cycle; any_change is a single one-cycle pulse.
